cache_refill_unit: RTL

Miss-refill and write-through drain engine sitting directly downstream of the 4-way L1 data cache (16-byte lines, write-through). It accepts a line-miss request from the cache, fetches the line from main memory as four 32-bit beats, and returns the assembled 128-bit line for installation. It also buffers the cache's write-through stores and drains them to memory over the same single-port memory interface. Any pending stores are retired before a refill read is issued, so refill data reflects every earlier store.

---
 rtl/cache_refill_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cache_refill_unit.sv
// Line-refill and write-through drain engine for a 4-way L1 data cache with 16-byte lines.
// Buffered stores are retired to memory before a refill read, so each fill reflects every earlier store.
module cache_refill_unit #(
    parameter int WB_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         miss_valid,
    input  logic [31:0]  miss_addr,
    output logic         miss_ready,
    output logic         fill_valid,
    output logic [31:0]  fill_addr,
    output logic [127:0] fill_data,
    input  logic         wt_valid,
    input  logic [31:0]  wt_addr,
    input  logic [31:0]  wt_data,
    input  logic         wt_size,
    output logic         wt_ready,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_req_we,
    output logic [31:0]  mem_req_addr,
    output logic [31:0]  mem_req_wdata,
    output logic [3:0]   mem_req_wstrb,
    input  logic         mem_rsp_valid,
    input  logic [31:0]  mem_rsp_data,
    output logic         busy
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = $clog2(WB_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(WB_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_REQ,
        S_WAIT,
        S_FILL
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]   r_wb_addr [WB_DEPTH];
    logic [31:0]   r_wb_data [WB_DEPTH];
    logic [3:0]    r_wb_strb [WB_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    logic [27:0]   r_line;
    logic [1:0]    r_beat;
    logic [31:0]   r_beat_data [3];
    logic [31:0]   r_fill_addr;
    logic [127:0]  r_fill_data;

    logic          w_push;
    logic          w_pop;
    logic          w_drain_req;
    logic          w_rsp;
    logic          w_miss_acc;
    logic [31:0]   w_wb_addr_in;
    logic [31:0]   w_wb_data_in;
    logic [3:0]    w_wb_strb_in;
    logic          w_unused;

    assign w_unused = ^miss_addr[3:0];

    assign miss_ready  = (r_state == S_IDLE);
    assign wt_ready    = (r_state == S_IDLE) && (r_count < DEPTH_C);
    assign busy        = (r_state != S_IDLE) || (r_count != '0);
    assign fill_valid  = (r_state == S_FILL);
    assign fill_addr   = r_fill_addr;
    assign fill_data   = r_fill_data;

    assign w_push      = wt_valid && wt_ready;
    assign w_drain_req = ((r_state == S_IDLE) || (r_state == S_DRAIN)) && (r_count != '0);
    assign w_pop       = w_drain_req && mem_req_ready;
    assign w_miss_acc  = miss_valid && miss_ready;
    assign w_rsp       = (r_state == S_WAIT) && mem_rsp_valid;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // Byte stores replicate the byte on all lanes; the strobe selects the lane.
    assign w_wb_addr_in = {wt_addr[31:2], 2'b00};
    assign w_wb_data_in = wt_size ? wt_data : {4{wt_data[7:0]}};
    assign w_wb_strb_in = wt_size ? 4'b1111 : (4'b0001 << wt_addr[1:0]);

    always_comb begin
        w_state_next  = r_state;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_wstrb = '0;

        if (w_drain_req) begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = r_wb_addr[r_rd_ptr];
            mem_req_wdata = r_wb_data[r_rd_ptr];
            mem_req_wstrb = r_wb_strb[r_rd_ptr];
        end else if (r_state == S_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {r_line, r_beat, 2'b00};
        end

        case (r_state)
            S_IDLE: begin
                // Drain decision uses the count after this cycle's push/pop.
                if (miss_valid) begin
                    w_state_next = (w_count_next != '0) ? S_DRAIN : S_REQ;
                end
            end
            S_DRAIN: begin
                if (w_count_next == '0) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    w_state_next = (r_beat == 2'd3) ? S_FILL : S_REQ;
                end
            end
            S_FILL:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_line      <= '0;
            r_beat      <= '0;
            r_fill_addr <= '0;
            r_fill_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_miss_acc) begin
                r_line <= miss_addr[31:4];
                r_beat <= '0;
            end
            if (w_rsp) begin
                if (r_beat == 2'd3) begin
                    r_fill_addr <= {r_line, 4'b0000};
                    r_fill_data <= {mem_rsp_data, r_beat_data[2], r_beat_data[1], r_beat_data[0]};
                end else begin
                    r_beat <= r_beat + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wb_addr[r_wr_ptr] <= w_wb_addr_in;
            r_wb_data[r_wr_ptr] <= w_wb_data_in;
            r_wb_strb[r_wr_ptr] <= w_wb_strb_in;
        end
        if (w_rsp) begin
            case (r_beat)
                2'd0:    r_beat_data[0] <= mem_rsp_data;
                2'd1:    r_beat_data[1] <= mem_rsp_data;
                2'd2:    r_beat_data[2] <= mem_rsp_data;
                default: ;
            endcase
        end
    end

endmodule
